tx_frame_scheduler: RTL and testbench

//  Shares the single UART TX byte path between two requesters: register-file read data (1 byte)
//  and ALU results (2 bytes, sent LSB first). Captures each result, arbitrates round-robin,

---
 rtl/tx_frame_scheduler.sv | 170 +++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Arbitrates register-file read bytes and 2-byte ALU results onto the single UART TX byte path,
// holding each byte with a valid-until-Busy handshake and a Busy-rise timeout.
module tx_frame_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TMO_WIDTH  = 8,
  parameter int unsigned TMO_CYCLES = 200
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    Busy,
  output logic [DATA_WIDTH-1:0]   TX_P_Data,
  output logic                    TX_D_VLD,
  output logic                    Sched_Busy,
  output logic                    Overrun_err,
  output logic                    Timeout_err
);

  localparam logic [TMO_WIDTH-1:0] TmoLast = TMO_WIDTH'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitHi, StWaitLo} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [2*DATA_WIDTH-1:0] alu_buf_q, alu_buf_d;
  logic                    alu_pend_q, alu_pend_d;
  logic                    last_alu_q, last_alu_d;
  logic [2*DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]              bytes_left_q, bytes_left_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [TMO_WIDTH-1:0]    tmo_q, tmo_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic                    grant_rd, grant_alu;

  // Round-robin: on a tie the requester that was not granted last wins.
  always_comb begin
    grant_rd  = 1'b0;
    grant_alu = 1'b0;
    if (state_q == StIdle) begin
      grant_rd  = rd_pend_q & (~alu_pend_q | last_alu_q);
      grant_alu = alu_pend_q & (~rd_pend_q | ~last_alu_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_buf_d     = rd_buf_q;
    rd_pend_d    = rd_pend_q;
    alu_buf_d    = alu_buf_q;
    alu_pend_d   = alu_pend_q;
    last_alu_d   = last_alu_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    tx_data_d    = tx_data_q;
    tx_vld_d     = tx_vld_q;
    tmo_d        = tmo_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (grant_rd) begin
          rd_pend_d                  = 1'b0;
          last_alu_d                 = 1'b0;
          shift_d                    = '0;
          shift_d[DATA_WIDTH-1:0]    = rd_buf_q;
          bytes_left_d               = 2'd1;
          state_d                    = StLoad;
        end else if (grant_alu) begin
          alu_pend_d   = 1'b0;
          last_alu_d   = 1'b1;
          shift_d      = alu_buf_q;
          bytes_left_d = 2'd2;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        tx_data_d = shift_q[DATA_WIDTH-1:0];
        shift_d   = shift_q >> DATA_WIDTH;
        tx_vld_d  = 1'b1;
        tmo_d     = '0;
        state_d   = StWaitHi;
      end
      StWaitHi: begin
        if (Busy) begin
          tx_vld_d = 1'b0;
          state_d  = StWaitLo;
        end else if (tmo_q == TmoLast) begin
          // Give up on the whole frame, not just this byte.
          tx_vld_d     = 1'b0;
          timeout_d    = 1'b1;
          bytes_left_d = 2'd0;
          state_d      = StIdle;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      StWaitLo: begin
        if (!Busy) begin
          bytes_left_d = bytes_left_q - 2'd1;
          state_d      = (bytes_left_q > 2'd1) ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture after the grant so a same-cycle pulse refills a buffer freed this cycle.
    if (RdData_VLD) begin
      if (!rd_pend_q || grant_rd) begin
        rd_buf_d  = RdData;
        rd_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (ALU_OUT_VLD) begin
      if (!alu_pend_q || grant_alu) begin
        alu_buf_d  = ALU_OUT;
        alu_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      rd_buf_q     <= '0;
      rd_pend_q    <= 1'b0;
      alu_buf_q    <= '0;
      alu_pend_q   <= 1'b0;
      last_alu_q   <= 1'b1;
      shift_q      <= '0;
      bytes_left_q <= 2'd0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      tmo_q        <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_buf_q     <= rd_buf_d;
      rd_pend_q    <= rd_pend_d;
      alu_buf_q    <= alu_buf_d;
      alu_pend_q   <= alu_pend_d;
      last_alu_q   <= last_alu_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      tmo_q        <= tmo_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign TX_P_Data   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign Sched_Busy  = rd_pend_q | alu_pend_q | (state_q != StIdle);
  assign Overrun_err = overrun_q;
  assign Timeout_err = timeout_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: a UART Busy responder, a byte scoreboard fed at
// stimulus time, a vector table for single frames and hand-written multi-cycle sequences.
module tb_tx_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RdData = '0;
  logic        RdData_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        Busy = 1'b0;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        Sched_Busy;
  logic        Overrun_err;
  logic        Timeout_err;

  tx_frame_scheduler #(
    .DATA_WIDTH(8),
    .TMO_WIDTH (8),
    .TMO_CYCLES(200)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RdData     (RdData),
    .RdData_VLD (RdData_VLD),
    .ALU_OUT    (ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD),
    .Busy       (Busy),
    .TX_P_Data  (TX_P_Data),
    .TX_D_VLD   (TX_D_VLD),
    .Sched_Busy (Sched_Busy),
    .Overrun_err(Overrun_err),
    .Timeout_err(Timeout_err)
  );

  initial forever #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         busy_dly = 3;
  int         busy_len = 10;
  logic       busy_auto = 1'b1;
  int         hi_cnt = 0;
  int         last_hi_cnt = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // UART model: Busy rises busy_dly cycles after TX_D_VLD is seen, stays high busy_len cycles.
  initial forever begin
    @(negedge CLK);
    if (busy_auto && TX_D_VLD) begin
      repeat (busy_dly) @(negedge CLK);
      Busy = 1'b1;
      repeat (busy_len) @(negedge CLK);
      Busy = 1'b0;
    end
  end

  // Byte monitor and handshake checks.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      vld_prev = 1'b0;
    end else begin
      if (TX_D_VLD && !vld_prev) begin
        chk("Busy low at byte issue", Busy, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected byte: got %0h, want none", TX_P_Data);
        end else begin
          chk("byte value", TX_P_Data, exp_q.pop_front());
        end
        hold_data = TX_P_Data;
        hi_cnt    = 1;
      end else if (TX_D_VLD) begin
        hi_cnt++;
        chk("byte held stable", TX_P_Data, hold_data);
      end else if (vld_prev) begin
        last_hi_cnt = hi_cnt;
        if (busy_auto) chk("valid dropped on Busy", Busy, 1'b1);
      end
      vld_prev = TX_D_VLD;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse(input logic rd, input logic [7:0] rdv, input logic alu,
                       input logic [15:0] aluv);
    @(posedge CLK); #1;
    RdData      = rdv;
    RdData_VLD  = rd;
    ALU_OUT     = aluv;
    ALU_OUT_VLD = alu;
    @(posedge CLK); #1;
    RdData_VLD  = 1'b0;
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge CLK);
    while ((Sched_Busy || Busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({name, " idle in time"}, n < budget, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST         = 1'b1;
    RdData_VLD  = 1'b0;
    ALU_OUT_VLD = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    logic        is_alu;
    logic [15:0] data;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          dly;
    int          len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{1'b0, 16'h00A5, 1, 8'hA5, 8'h00, 3, 10};
    vecs[1] = '{1'b1, 16'h1234, 2, 8'h34, 8'h12, 2, 5};
    vecs[2] = '{1'b0, 16'h003C, 1, 8'h3C, 8'h00, 1, 2};
    vecs[3] = '{1'b1, 16'hFF00, 2, 8'h00, 8'hFF, 5, 3};

    do_reset();
    @(negedge CLK);
    chk("reset outputs", {TX_P_Data, TX_D_VLD, Sched_Busy, Overrun_err, Timeout_err}, 0);

    // Single frames from idle: latency, byte order, valid width.
    foreach (vecs[i]) begin
      busy_dly = vecs[i].dly;
      busy_len = vecs[i].len;
      exp_q.push_back(vecs[i].b0);
      if (vecs[i].nb == 2) exp_q.push_back(vecs[i].b1);
      pulse(!vecs[i].is_alu, vecs[i].data[7:0], vecs[i].is_alu, vecs[i].data);
      repeat (2) @(negedge CLK);
      chk($sformatf("v%0d valid before N+2", i), TX_D_VLD, 1'b0);
      @(negedge CLK);
      chk($sformatf("v%0d valid at N+2", i), TX_D_VLD, 1'b1);
      wait_idle(300, $sformatf("v%0d", i));
      chk($sformatf("v%0d valid width", i), last_hi_cnt, vecs[i].dly + 1);
      chk($sformatf("v%0d drained", i), exp_q.size(), 0);
      chk($sformatf("v%0d no errors", i), {Overrun_err, Timeout_err}, 0);
    end

    // Tie after reset: RD first, then ALU LSB/MSB.
    do_reset();
    busy_dly = 2;
    busy_len = 4;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    pulse(1'b1, 8'h55, 1'b1, 16'hBEEF);
    wait_idle(300, "tie");
    chk("tie drained", exp_q.size(), 0);
    // RD granted last, so the next tie goes to ALU.
    exp_q.push_back(8'h11);
    pulse(1'b1, 8'h11, 1'b0, 16'h0000);
    wait_idle(300, "rd only");
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    pulse(1'b1, 8'h44, 1'b1, 16'h3322);
    wait_idle(300, "tie alu first");
    chk("tie alu first drained", exp_q.size(), 0);

    // Overrun: second ALU pulse while the first is still pending behind an RD frame.
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    @(posedge CLK); #1;
    RdData = 8'h77; RdData_VLD = 1'b1;
    @(posedge CLK); #1;
    RdData_VLD = 1'b0; ALU_OUT = 16'h0001; ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT = 16'h0002;
    @(negedge CLK);
    chk("no overrun yet", Overrun_err, 1'b0);
    @(posedge CLK); #1;
    ALU_OUT_VLD = 1'b0;
    @(negedge CLK);
    chk("overrun flagged", Overrun_err, 1'b1);
    wait_idle(300, "overrun");
    chk("overrun drained", exp_q.size(), 0);
    chk("overrun sticky", Overrun_err, 1'b1);

    // Timeout: Busy never rises.
    do_reset();
    @(negedge CLK);
    chk("overrun cleared by reset", Overrun_err, 1'b0);
    busy_auto = 1'b0;
    exp_q.push_back(8'h0F);
    pulse(1'b1, 8'h0F, 1'b0, 16'h0000);
    wait_idle(400, "timeout rd");
    chk("timeout valid width", last_hi_cnt, 200);
    chk("timeout flagged", Timeout_err, 1'b1);
    chk("timeout sched idle", Sched_Busy, 1'b0);
    exp_q.push_back(8'hCD);
    pulse(1'b0, 8'h00, 1'b1, 16'hABCD);
    wait_idle(400, "timeout alu");
    repeat (5) @(negedge CLK);
    chk("timeout drops frame", exp_q.size(), 0);
    busy_auto = 1'b1;
    do_reset();
    @(negedge CLK);
    chk("timeout cleared by reset", Timeout_err, 1'b0);

    // Reset in WAIT_LO of an ALU frame.
    busy_dly = 2;
    busy_len = 10;
    exp_q.push_back(8'hB2);
    pulse(1'b0, 8'h00, 1'b1, 16'hA1B2);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(!TX_D_VLD && Busy && Sched_Busy) && n < 100);
    chk("reached wait_lo", n < 100, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid-frame reset outputs",
        {TX_P_Data, TX_D_VLD, Sched_Busy, Overrun_err, Timeout_err}, 0);
    RST = 1'b0;
    repeat (15) @(negedge CLK);
    chk("no byte after reset", exp_q.size(), 0);
    exp_q.push_back(8'h3C);
    pulse(1'b1, 8'h3C, 1'b0, 16'h0000);
    wait_idle(300, "after reset");
    chk("after reset drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
